// File: rtl/alu_muldiv.sv
// ALU with optional multi-cycle multiply/divide.
// Single-cycle ops complete one cycle after accept. MUL (shift-add) and
// DIV (restoring) run for WIDTH cycles in CALC and are built only when the
// macro ALU_MULDIV_EN is defined; otherwise their codes behave as "pass DB".
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [WIDTH-1:0] ALU_DA,
    input  logic [WIDTH-1:0] ALU_DB,
    input  logic [3:0]       ALU_Func,
    input  logic             ALU_Sign,
    input  logic             ALU_Start,
    output logic             ALU_Busy,
    output logic             ALU_Done,
    output logic [WIDTH-1:0] ALU_DC,
    output logic [WIDTH-1:0] ALU_HI,
    output logic             ALU_Zero,
    output logic             ALU_OverFlow
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned CW   = $clog2(WIDTH);

    localparam logic [3:0] F_PASS = 4'b0000;
    localparam logic [3:0] F_ADD  = 4'b0001;
    localparam logic [3:0] F_ADDV = 4'b0010;
    localparam logic [3:0] F_SUB  = 4'b0011;
    localparam logic [3:0] F_SUBV = 4'b0100;
    localparam logic [3:0] F_AND  = 4'b0101;
    localparam logic [3:0] F_OR   = 4'b0110;
    localparam logic [3:0] F_NOR  = 4'b0111;
    localparam logic [3:0] F_XOR  = 4'b1000;
    localparam logic [3:0] F_SLTU = 4'b1001;
    localparam logic [3:0] F_SLT  = 4'b1010;
    localparam logic [3:0] F_SLE  = 4'b1011;
    localparam logic [3:0] F_LUI  = 4'b1100;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] F_MUL  = 4'b1101;
    localparam logic [3:0] F_DIV  = 4'b1110;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dc_q, dc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, done_q;

    logic             accept_c;
    logic             start_multi_c;
    logic [WIDTH-1:0] add_c, sub_c;
    logic [WIDTH-1:0] sc_dc_c;
    logic             sc_ovf_c;

    assign accept_c = ALU_Start && (state_q != S_CALC);
    assign add_c    = ALU_DA + ALU_DB;
    assign sub_c    = ALU_DA - ALU_DB;

`ifdef ALU_MULDIV_EN
    // Iteration state: acc holds the product high half / partial remainder,
    // lo holds the multiplier being shifted out / dividend shifting into quotient.
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] da_q, da_d;
    logic             is_div_q, is_div_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dbz_q, dbz_d;
    logic             ovdiv_q, ovdiv_d;

    logic             a_neg_c, b_neg_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_sh_c;
    logic             div_ge_c;
    logic [WIDTH-1:0] step_acc_c, step_lo_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0] fin_dc_c, fin_hi_c;
    logic             fin_ovf_c;

    assign start_multi_c = (ALU_Func == F_MUL) || (ALU_Func == F_DIV);

    // Operand signs and magnitudes; the core iterates on unsigned magnitudes.
    always_comb begin
        a_neg_c = ALU_Sign & ALU_DA[WIDTH-1];
        b_neg_c = ALU_Sign & ALU_DB[WIDTH-1];
        a_mag_c = a_neg_c ? (~ALU_DA + WIDTH'(1)) : ALU_DA;
        b_mag_c = b_neg_c ? (~ALU_DB + WIDTH'(1)) : ALU_DB;
    end

    // One shift-add or restoring-division step, plus sign fix-up of the final step.
    always_comb begin
        mul_sum_c = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        div_sh_c  = {acc_q, lo_q[WIDTH-1]};
        div_ge_c  = (div_sh_c >= {1'b0, mcand_q});
        if (is_div_q) begin
            step_acc_c = div_ge_c ? WIDTH'(div_sh_c - {1'b0, mcand_q}) : div_sh_c[WIDTH-1:0];
            step_lo_c  = {lo_q[WIDTH-2:0], div_ge_c};
        end else begin
            step_acc_c = mul_sum_c[WIDTH:1];
            step_lo_c  = {mul_sum_c[0], lo_q[WIDTH-1:1]};
        end

        prod_c    = {step_acc_c, step_lo_c};
        fin_dc_c  = '0;
        fin_hi_c  = '0;
        fin_ovf_c = 1'b0;
        if (is_div_q) begin
            fin_dc_c = qneg_q ? (~step_lo_c + WIDTH'(1)) : step_lo_c;
            fin_hi_c = rneg_q ? (~step_acc_c + WIDTH'(1)) : step_acc_c;
            if (dbz_q) begin
                fin_dc_c  = '1;
                fin_hi_c  = da_q;
                fin_ovf_c = 1'b1;
            end else begin
                fin_ovf_c = ovdiv_q;
            end
        end else begin
            if (qneg_q) begin
                prod_c = ~prod_c + (2*WIDTH)'(1);
            end
            fin_dc_c = prod_c[WIDTH-1:0];
            fin_hi_c = prod_c[2*WIDTH-1:WIDTH];
        end
    end
`else
    logic unused_sign_c;

    assign start_multi_c = 1'b0;
    assign unused_sign_c = ALU_Sign;
`endif

    // Single-cycle result and overflow for the current inputs.
    always_comb begin
        sc_dc_c  = ALU_DB;
        sc_ovf_c = 1'b0;
        case (ALU_Func)
            F_PASS: sc_dc_c = ALU_DB;
            F_ADD:  sc_dc_c = add_c;
            F_ADDV: begin
                sc_dc_c  = add_c;
                sc_ovf_c = (ALU_DA[WIDTH-1] == ALU_DB[WIDTH-1]) &&
                           (add_c[WIDTH-1] != ALU_DA[WIDTH-1]);
            end
            F_SUB:  sc_dc_c = sub_c;
            F_SUBV: begin
                sc_dc_c  = sub_c;
                sc_ovf_c = (ALU_DA[WIDTH-1] != ALU_DB[WIDTH-1]) &&
                           (sub_c[WIDTH-1] != ALU_DA[WIDTH-1]);
            end
            F_AND:  sc_dc_c = ALU_DA & ALU_DB;
            F_OR:   sc_dc_c = ALU_DA | ALU_DB;
            F_NOR:  sc_dc_c = ~(ALU_DA | ALU_DB);
            F_XOR:  sc_dc_c = ALU_DA ^ ALU_DB;
            F_SLTU: sc_dc_c = WIDTH'(ALU_DA < ALU_DB);
            F_SLT:  sc_dc_c = WIDTH'($signed(ALU_DA) < $signed(ALU_DB));
            F_SLE:  sc_dc_c = WIDTH'($signed(ALU_DA) <= $signed(ALU_DB));
            F_LUI:  sc_dc_c = {ALU_DB[HALF-1:0], {HALF{1'b0}}};
            default: sc_dc_c = ALU_DB;
        endcase
    end

    // Next-state and result update logic.
    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`ifdef ALU_MULDIV_EN
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        da_d     = da_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        ovdiv_d  = ovdiv_q;
`endif
        case (state_q)
            S_CALC: begin
`ifdef ALU_MULDIV_EN
                cnt_d = cnt_q + CW'(1);
                acc_d = step_acc_c;
                lo_d  = step_lo_c;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    dc_d    = fin_dc_c;
                    hi_d    = fin_hi_c;
                    zero_d  = (fin_dc_c == '0);
                    ovf_d   = fin_ovf_c;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                if (accept_c) begin
                    if (start_multi_c) begin
                        state_d = S_CALC;
`ifdef ALU_MULDIV_EN
                        is_div_d = (ALU_Func == F_DIV);
                        cnt_d    = '0;
                        acc_d    = '0;
                        lo_d     = (ALU_Func == F_DIV) ? a_mag_c : b_mag_c;
                        mcand_d  = (ALU_Func == F_DIV) ? b_mag_c : a_mag_c;
                        da_d     = ALU_DA;
                        qneg_d   = a_neg_c ^ b_neg_c;
                        rneg_d   = a_neg_c;
                        dbz_d    = (ALU_DB == '0);
                        ovdiv_d  = ALU_Sign && (ALU_DA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                   (ALU_DB == '1);
`endif
                    end else begin
                        state_d = S_DONE;
                        dc_d    = sc_dc_c;
                        hi_d    = '0;
                        zero_d  = (sc_dc_c == '0);
                        ovf_d   = sc_ovf_c;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            dc_q    <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            da_q     <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            ovdiv_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dc_q    <= dc_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == S_CALC);
            done_q  <= (state_d == S_DONE);
`ifdef ALU_MULDIV_EN
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            da_q     <= da_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            ovdiv_q  <= ovdiv_d;
`endif
        end
    end

    assign ALU_Busy     = busy_q;
    assign ALU_Done     = done_q;
    assign ALU_DC       = dc_q;
    assign ALU_HI       = hi_q;
    assign ALU_Zero     = zero_q;
    assign ALU_OverFlow = ovf_q;

endmodule
